fsm_b: RTL and testbench



---
 rtl/fsm_b.sv | 78 +++++++
 tb/tb_fsm_b.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fsm_b.sv
// fsm_b: serial "1101" pattern detector (Mealy).
// Watches one bit of x_in per CLK cycle and raises y_out combinationally in
// the cycle that carries the final '1' of "1101". Overlapping matches count,
// so "1101101" reports twice. Reset is synchronous and active-high, and it
// also gates y_out directly so that a match never reports while Reset is held.

module fsm_b (
  input  logic CLK,
  input  logic Reset,
  input  logic x_in,
  output logic y_out
);

  // Each state records how much of the pattern the recent bits have matched.
  typedef enum logic [1:0] {
    S0 = 2'b00,  // no useful prefix
    S1 = 2'b01,  // seen "1"
    S2 = 2'b10,  // seen "11"
    S3 = 2'b11   // seen "110"
  } state_t;

  state_t state_r;
  state_t next_state_s;

  // State register: synchronous reset to S0, otherwise take the computed next state.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r <= S0;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and Mealy output logic; y_out fires only on the completing '1' from S3.
  always_comb begin
    next_state_s = S0;
    y_out        = 1'b0;
    case (state_r)
      S0: begin
        if (x_in) begin
          next_state_s = S1;
        end else begin
          next_state_s = S0;
        end
      end
      S1: begin
        if (x_in) begin
          next_state_s = S2;
        end else begin
          next_state_s = S0;
        end
      end
      S2: begin
        // A run of 1s still ends in "11", so stay here.
        if (x_in) begin
          next_state_s = S2;
        end else begin
          next_state_s = S3;
        end
      end
      S3: begin
        // The completing '1' is also the first '1' of a possible next match.
        if (x_in) begin
          next_state_s = S1;
          y_out        = ~Reset;
        end else begin
          next_state_s = S0;
          y_out        = 1'b0;
        end
      end
      default: begin
        next_state_s = S0;
        y_out        = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fsm_b.sv
// tb_fsm_b: self-checking bench for the "1101" detector.
// Directed sequences carry their own expected output vectors; the random
// phase compares against a reference that simply remembers the bits seen
// since the last reset and asks whether the newest four spell "1101".

module tb_fsm_b;

  logic CLK;
  logic Reset;
  logic x_in;
  logic y_out;

  int tests_run;
  int tests_failed;

  // Reference model: bits received since the last reset (newest in bit 0).
  logic [2:0] hist;
  int         nbits;

  fsm_b dut (
    .CLK   (CLK),
    .Reset (Reset),
    .x_in  (x_in),
    .y_out (y_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count one comparison; report it when the observed value differs from the expected one.
  task automatic check_bit(input string tag, input logic observed, input logic expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: y_out=%b expected=%b at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference prediction for the current cycle from history plus the present input.
  function automatic logic model_y(input logic rst, input logic x);
    logic [3:0] last4;
    last4 = {hist, x};
    return (!rst && nbits >= 3 && last4 == 4'b1101) ? 1'b1 : 1'b0;
  endfunction

  // Advance the reference by one clock edge with the given inputs.
  task automatic model_update(input logic rst, input logic x);
    if (rst) begin
      hist  = 3'b000;
      nbits = 0;
    end else begin
      hist  = {hist[1:0], x};
      nbits = nbits + 1;
    end
  endtask

  // One cycle: drive just after the rising edge, check at the falling edge.
  // When use_model is 0 the supplied expected value is used instead of the reference.
  task automatic step(input logic rst, input logic x, input logic exp_y,
                      input logic use_model, input string tag);
    logic e;
    @(posedge CLK);
    #1;
    Reset = rst;
    x_in  = x;
    @(negedge CLK);
    e = use_model ? model_y(rst, x) : exp_y;
    check_bit(tag, y_out, e);
    model_update(rst, x);
  endtask

  // Play n bits (bits[n-1] first) with Reset low, checking against an explicit vector.
  task automatic run_seq(input string tag, input logic [7:0] bits,
                         input logic [7:0] exp_v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b0, bits[i], exp_v[i], 1'b0, tag);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    hist         = 3'b000;
    nbits        = 0;
    Reset        = 1'b1;
    x_in         = 1'b1;

    // 1: reset held two cycles with x_in=1, then the basic pattern.
    step(1'b1, 1'b1, 1'b0, 1'b0, "reset_hold0");
    step(1'b1, 1'b1, 1'b0, 1'b0, "reset_hold1");
    run_seq("basic_1101", 8'b0000_1101, 8'b0000_0001, 4);

    // 2: overlapping occurrences.
    step(1'b1, 1'b0, 1'b0, 1'b0, "reset2");
    run_seq("overlap", 8'b0110_1101, 8'b0000_1001, 7);

    // 3: run of ones stays in "11".
    step(1'b1, 1'b0, 1'b0, 1'b0, "reset3");
    run_seq("ones_run", 8'b0011_1101, 8'b0000_0001, 6);

    // 3b: longer run of ones, single detection at the end.
    step(1'b1, 1'b0, 1'b0, 1'b0, "reset3b");
    run_seq("ones_run7", 8'b0111_1101, 8'b0000_0001, 7);

    // 4: broken pattern, "101" alone is insufficient.
    step(1'b1, 1'b0, 1'b0, 1'b0, "reset4");
    run_seq("broken", 8'b0110_0101, 8'b0000_0000, 7);

    // 5: reset while in "110" with x_in=1, then restart from scratch.
    step(1'b1, 1'b0, 1'b0, 1'b0, "reset5");
    run_seq("prefix_110", 8'b0000_0110, 8'b0000_0000, 3);
    step(1'b1, 1'b1, 1'b0, 1'b0, "reset_in_s3");
    step(1'b0, 1'b1, 1'b0, 1'b0, "after_reset");
    run_seq("resume", 8'b0000_0101, 8'b0000_0001, 3);

    // Random phase: biased bits with occasional resets, checked against the reference.
    step(1'b1, 1'b0, 1'b0, 1'b0, "reset_rand");
    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic b;
      r = ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0;
      b = ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0;
      step(r, b, 1'b0, 1'b1, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run can never hang.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, run incomplete");
    $fatal(1, "watchdog expired");
  end

endmodule
